exe_mdu: RTL and testbench
==========================

EXE_MDU -- requirements
Module: exe_mdu

Interface
REQ-001 SHALL have port clk, input, 1: sole clock, rising edge.
REQ-002 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-003 SHALL have port EXE_MDUOp, input, 3: MDUOpType op of the instruction in EXE (NOP, MULT, MULTU, DIV, DIVU, MTHI, MTLO).
REQ-004 SHALL have port EXE_SrcA, input, 32: rs operand after the EXE forwarding mux.
REQ-005 SHALL have port EXE_SrcB, input, 32: rt operand after the EXE forwarding mux.
REQ-006 SHALL have port EXE_Flush, input, 1: exception flush of the EXE stage.
REQ-007 SHALL have port EXE_MDUBusy, output, 1: stall request holding IF/ID/EXE.
REQ-008 SHALL have port EXE_HI, output, 32: HI write data.
REQ-009 SHALL have port EXE_LO, output, 32: LO write data.
REQ-010 SHALL have port EXE_HIWr, output, 1: HI write enable; feeds RegsWrType.HIWr of the EXE/MEM register.
REQ-011 SHALL have port EXE_LOWr, output, 1: LO write enable; feeds RegsWrType.LOWr of the EXE/MEM register.

Function
REQ-012 SHALL implement FSM states IDLE, MUL, DIV, DONE.
REQ-013 SHALL define start as: state==IDLE, op in {MULT, MULTU, DIV, DIVU}, and !EXE_Flush.
REQ-014 SHALL assert EXE_MDUBusy combinationally when start holds, and throughout MUL-entry and DIV states; SHALL hold it low in IDLE without start and in DONE.
REQ-015 SHALL transition, on start with MULT/MULTU, IDLE->MUL; the product is registered at that edge and MUL presents it with HIWr=LOWr=1, Busy=0; MUL->IDLE next edge (2 EXE cycles total).
REQ-016 SHALL transition, on start with DIV/DIVU, IDLE->DIV: 32 cycles of radix-2 restoring iteration, 5-bit counter 31 down to 0, then DIV->DONE.
REQ-017 SHALL, in DONE, present quotient on EXE_LO and remainder on EXE_HI with HIWr=LOWr=1; DONE->IDLE next edge (34 EXE cycles total).
REQ-018 SHALL latch operands at start; EXE_SrcA/B changes after start SHALL be ignored.
REQ-019 SHALL, for signed ops, compute on magnitudes with quotient sign = signA^signB and remainder sign = signA; 0x80000000/0xFFFFFFFF SHALL give LO=0x80000000, HI=0.
REQ-020 SHALL, on divide by zero, give LO=0xFFFFFFFF and HI=dividend (|dividend| re-signed for DIV), with no exception and unchanged latency.
REQ-021 SHALL, for MTHI/MTLO in IDLE, pass EXE_SrcA combinationally to EXE_HI/EXE_LO with only the matching Wr asserted, zero latency, Busy=0.
REQ-022 SHALL, with EXE_Flush high in any state, force HIWr/LOWr/Busy to 0 that cycle and enter IDLE at the next edge.
REQ-023 SHALL drive EXE_HI/EXE_LO to 0 whenever their Wr is 0.
REQ-024 SHALL, when a back-to-back DIV arrives in the cycle after DONE, start normally from IDLE.

Reset
REQ-025 SHALL, with rst high at a clock edge, enter IDLE, clear counter and operand/partial registers, and drive all outputs to 0 in the following cycle; reset mid-DIV SHALL discard the operation with no write.

Configuration
REQ-026 SHALL compile MULT/MULTU support only when MDU_MULT_EN is defined; without it, MULT/MULTU SHALL be treated as NOP (no Busy, no writes) and the MUL state and multiplier SHALL not exist.

Structure
REQ-027 SHALL place MDUOpType, the MDU state enum and DIV_CYCLES=32 in the shared CPU defines package.
REQ-028 SHALL instantiate the iterative divider datapath as sub-module mdu_div_core (operand/partial-remainder registers, step counter); exe_mdu SHALL own the FSM, sign fix-up, and output muxing.

Verification
REQ-029 SHALL cover: DIVU 100,7 -> Busy high 33 cycles, then DONE cycle with LO=14, HI=2, both Wr=1.
REQ-030 SHALL cover: DIV 0xFFFFFF9C(-100),7 -> LO=0xFFFFFFF2(-14), HI=0xFFFFFFFE(-2); and DIV 0x80000000,0xFFFFFFFF -> LO=0x80000000, HI=0.
REQ-031 SHALL cover: MULT 0xFFFFFFFF,2 with MDU_MULT_EN -> second cycle HI=0xFFFFFFFF, LO=0xFFFFFFFE; without the macro -> Busy=0, no writes.
REQ-032 SHALL cover: MTHI 0x12345678 -> same cycle HIWr=1, HI=0x12345678, LOWr=0, Busy=0.
REQ-033 SHALL cover: EXE_Flush at DIV step 10 -> no Wr ever asserted, IDLE next cycle, following DIVU 9,3 -> LO=3, HI=0.
REQ-034 SHALL cover: DIVU 5,0 -> LO=0xFFFFFFFF, HI=5 after 34 cycles; rst asserted mid-DIV -> all outputs 0 next cycle.

Source files
------------

// File: rtl/exe_mdu_pkg.sv
// Shared CPU defines for the EXE-stage multiply/divide unit: op codes, FSM states, divider length.
// MULT/MULTU and the MUL state exist only when MDU_MULT_EN is defined.
package exe_mdu_pkg;

  typedef enum logic [2:0] {
    MDU_NOP   = 3'd0,
    MDU_MULT  = 3'd1,
    MDU_MULTU = 3'd2,
    MDU_DIV   = 3'd3,
    MDU_DIVU  = 3'd4,
    MDU_MTHI  = 3'd5,
    MDU_MTLO  = 3'd6
  } mdu_op_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
`ifdef MDU_MULT_EN
    S_MUL  = 2'd1,
`endif
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } mdu_state_t;

  localparam int DIV_CYCLES = 32;
  localparam int DIV_CNT_W  = $clog2(DIV_CYCLES);

  // Two's-complement negate when neg is set; used both for |x| and for re-signing.
  function automatic logic [31:0] mag32(input logic [31:0] v, input logic neg);
    return neg ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/exe_mdu_div_core.sv
// Radix-2 restoring divider datapath: operand and partial-remainder registers plus the step counter.
// Works on unsigned magnitudes; the caller handles signs.
module mdu_div_core
  import exe_mdu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        step,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic [31:0] quotient,
  output logic [31:0] remainder,
  output logic        last,
  output logic        divisor_zero
);

  logic [31:0]          quo_q;
  logic [31:0]          rem_q;
  logic [31:0]          dsr_q;
  logic [DIV_CNT_W-1:0] cnt_q;
  logic [32:0]          shifted;
  logic [33:0]          diff;
  logic                 unused_diff_bit;

  // The quotient register doubles as the dividend shifter: its MSB feeds the remainder.
  assign shifted         = {rem_q, quo_q[31]};
  assign diff            = {1'b0, shifted} - {2'b00, dsr_q};
  assign unused_diff_bit = diff[32];

  always_ff @(posedge clk) begin
    if (rst) begin
      quo_q <= '0;
      rem_q <= '0;
      dsr_q <= '0;
      cnt_q <= '0;
    end else if (load) begin
      quo_q <= dividend;
      rem_q <= '0;
      dsr_q <= divisor;
      cnt_q <= DIV_CNT_W'(DIV_CYCLES - 1);
    end else if (step) begin
      if (!diff[33]) begin
        rem_q <= diff[31:0];
        quo_q <= {quo_q[30:0], 1'b1};
      end else begin
        rem_q <= shifted[31:0];
        quo_q <= {quo_q[30:0], 1'b0};
      end
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign quotient     = quo_q;
  assign remainder    = rem_q;
  assign last         = (cnt_q == '0);
  assign divisor_zero = (dsr_q == '0);

endmodule

// File: rtl/exe_mdu.sv
// EXE-stage multiply/divide unit: FSM, sign fix-up and HI/LO output muxing around mdu_div_core.
// Define MDU_MULT_EN to build MULT/MULTU support (MUL state and multiplier).
//
// state  | meaning
// IDLE   | waiting; MTHI/MTLO pass through; MULT/DIV start here
// MUL    | product registered, written to HI/LO this cycle
// DIV    | 32 restoring steps, counter 31 down to 0
// DONE   | quotient to LO, remainder to HI
module exe_mdu
  import exe_mdu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  EXE_MDUOp,
  input  logic [31:0] EXE_SrcA,
  input  logic [31:0] EXE_SrcB,
  input  logic        EXE_Flush,
  output logic        EXE_MDUBusy,
  output logic [31:0] EXE_HI,
  output logic [31:0] EXE_LO,
  output logic        EXE_HIWr,
  output logic        EXE_LOWr
);

  mdu_state_t  state_q;
  logic        q_neg_q;
  logic        r_neg_q;
  logic        is_div_op;
  logic        is_signed;
  logic        start;
  logic        div_load;
  logic        div_step;
  logic        div_last;
  logic        div_zero;
  logic [31:0] div_quo;
  logic [31:0] div_rem;
  logic [31:0] quo_fix;
  logic [31:0] rem_fix;

  assign is_div_op = (EXE_MDUOp == MDU_DIV) || (EXE_MDUOp == MDU_DIVU);
  assign is_signed = (EXE_MDUOp == MDU_DIV) || (EXE_MDUOp == MDU_MULT);

`ifdef MDU_MULT_EN
  logic        is_mul_op;
  logic [63:0] ext_a;
  logic [63:0] ext_b;
  logic [63:0] prod_q;

  assign is_mul_op = (EXE_MDUOp == MDU_MULT) || (EXE_MDUOp == MDU_MULTU);
  assign start     = (state_q == S_IDLE) && (is_div_op || is_mul_op) && !EXE_Flush;
  // Sign-extending to 64 bits makes one unsigned multiply correct for both MULT and MULTU.
  assign ext_a     = {{32{is_signed & EXE_SrcA[31]}}, EXE_SrcA};
  assign ext_b     = {{32{is_signed & EXE_SrcB[31]}}, EXE_SrcB};
`else
  assign start     = (state_q == S_IDLE) && is_div_op && !EXE_Flush;
`endif

  assign div_load = start && is_div_op;
  assign div_step = (state_q == S_DIV) && !EXE_Flush;

  mdu_div_core u_div_core (
    .clk          (clk),
    .rst          (rst),
    .load         (div_load),
    .step         (div_step),
    .dividend     (mag32(EXE_SrcA, is_signed & EXE_SrcA[31])),
    .divisor      (mag32(EXE_SrcB, is_signed & EXE_SrcB[31])),
    .quotient     (div_quo),
    .remainder    (div_rem),
    .last         (div_last),
    .divisor_zero (div_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
`ifdef MDU_MULT_EN
      prod_q  <= '0;
`endif
    end else if (EXE_Flush) begin
      state_q <= S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (div_load) begin
            state_q <= S_DIV;
            q_neg_q <= is_signed & (EXE_SrcA[31] ^ EXE_SrcB[31]);
            r_neg_q <= is_signed & EXE_SrcA[31];
          end
`ifdef MDU_MULT_EN
          else if (start) begin
            state_q <= S_MUL;
            prod_q  <= ext_a * ext_b;
          end
`endif
        end
`ifdef MDU_MULT_EN
        S_MUL:   state_q <= S_IDLE;
`endif
        S_DIV:   if (div_last) state_q <= S_DONE;
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Divide by zero keeps the all-ones quotient unsigned; the remainder re-signs back to the dividend.
  assign quo_fix = div_zero ? 32'hFFFF_FFFF : mag32(div_quo, q_neg_q);
  assign rem_fix = mag32(div_rem, r_neg_q);

  always_comb begin
    EXE_MDUBusy = 1'b0;
    EXE_HIWr    = 1'b0;
    EXE_LOWr    = 1'b0;
    EXE_HI      = '0;
    EXE_LO      = '0;
    if (!EXE_Flush) begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            EXE_MDUBusy = 1'b1;
          end else if (EXE_MDUOp == MDU_MTHI) begin
            EXE_HIWr = 1'b1;
            EXE_HI   = EXE_SrcA;
          end else if (EXE_MDUOp == MDU_MTLO) begin
            EXE_LOWr = 1'b1;
            EXE_LO   = EXE_SrcA;
          end
        end
`ifdef MDU_MULT_EN
        S_MUL: begin
          EXE_HIWr = 1'b1;
          EXE_LOWr = 1'b1;
          EXE_HI   = prod_q[63:32];
          EXE_LO   = prod_q[31:0];
        end
`endif
        S_DIV: EXE_MDUBusy = 1'b1;
        S_DONE: begin
          EXE_HIWr = 1'b1;
          EXE_LOWr = 1'b1;
          EXE_HI   = rem_fix;
          EXE_LO   = quo_fix;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_exe_mdu.sv
// Self-checking bench for exe_mdu: directed corner cases plus randomized DIV/DIVU/MT*/MULT traffic
// against an arithmetic reference model. Honors MDU_MULT_EN for MULT expectations.
module tb_exe_mdu;
  import exe_mdu_pkg::*;

  logic        clk;
  logic        rst;
  logic [2:0]  EXE_MDUOp;
  logic [31:0] EXE_SrcA;
  logic [31:0] EXE_SrcB;
  logic        EXE_Flush;
  logic        EXE_MDUBusy;
  logic [31:0] EXE_HI;
  logic [31:0] EXE_LO;
  logic        EXE_HIWr;
  logic        EXE_LOWr;

  int n_checks = 0;
  int n_errors = 0;

  exe_mdu dut (
    .clk         (clk),
    .rst         (rst),
    .EXE_MDUOp   (EXE_MDUOp),
    .EXE_SrcA    (EXE_SrcA),
    .EXE_SrcB    (EXE_SrcB),
    .EXE_Flush   (EXE_Flush),
    .EXE_MDUBusy (EXE_MDUBusy),
    .EXE_HI      (EXE_HI),
    .EXE_LO      (EXE_LO),
    .EXE_HIWr    (EXE_HIWr),
    .EXE_LOWr    (EXE_LOWr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  // Reference: divide magnitudes, sign the quotient by signA^signB and the remainder by signA.
  function automatic void div_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] q, output logic [31:0] r);
    logic        sa, sb;
    logic [31:0] ma, mb;
    sa = (op == MDU_DIV) && a[31];
    sb = (op == MDU_DIV) && b[31];
    ma = sa ? -a : a;
    mb = sb ? -b : b;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else begin
      q = ma / mb;
      r = ma % mb;
      if (sa ^ sb) q = -q;
      if (sa) r = -r;
    end
  endfunction

  task automatic next_cycle();
    @(posedge clk); #1;
    EXE_MDUOp = MDU_NOP;
    EXE_SrcA  = $urandom;
    EXE_SrcB  = $urandom;
    EXE_Flush = 1'b0;
  endtask

  task automatic chk_idle(input string tag);
    @(negedge clk);
    chk({tag, " ctl"}, 32'({EXE_MDUBusy, EXE_HIWr, EXE_LOWr}), 32'd0);
    chk({tag, " hi"}, EXE_HI, 32'd0);
    chk({tag, " lo"}, EXE_LO, 32'd0);
    next_cycle();
  endtask

  task automatic run_div(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input string tag);
    logic [31:0] eq, er;
    int          busy_n;
    bit          done;
    div_model(op, a, b, eq, er);
    EXE_MDUOp = op;
    EXE_SrcA  = a;
    EXE_SrcB  = b;
    busy_n    = 0;
    done      = 0;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      if (EXE_HIWr || EXE_LOWr) begin
        done = 1;
        chk({tag, " wr"}, 32'({EXE_HIWr, EXE_LOWr}), 32'd3);
        chk({tag, " lo"}, EXE_LO, eq);
        chk({tag, " hi"}, EXE_HI, er);
        chk({tag, " busy_at_done"}, 32'(EXE_MDUBusy), 32'd0);
      end else if (EXE_MDUBusy) begin
        busy_n++;
      end
      next_cycle();
    end
    chk({tag, " done_seen"}, 32'(done), 32'd1);
    chk({tag, " busy_cycles"}, busy_n, 32'd33);
  endtask

  task automatic run_mt(input logic [2:0] op, input logic [31:0] a, input string tag);
    EXE_MDUOp = op;
    EXE_SrcA  = a;
    @(negedge clk);
    chk({tag, " ctl"}, 32'({EXE_MDUBusy, EXE_HIWr, EXE_LOWr}),
        (op == MDU_MTHI) ? 32'd2 : 32'd1);
    chk({tag, " hi"}, EXE_HI, (op == MDU_MTHI) ? a : 32'd0);
    chk({tag, " lo"}, EXE_LO, (op == MDU_MTLO) ? a : 32'd0);
    next_cycle();
  endtask

  task automatic run_mul(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input string tag);
`ifdef MDU_MULT_EN
    longint      sa, sb;
    logic [63:0] p;
    if (op == MDU_MULT) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      p  = 64'(sa * sb);
    end else begin
      p = {32'd0, a} * {32'd0, b};
    end
`endif
    EXE_MDUOp = op;
    EXE_SrcA  = a;
    EXE_SrcB  = b;
    @(negedge clk);
`ifdef MDU_MULT_EN
    chk({tag, " start_ctl"}, 32'({EXE_MDUBusy, EXE_HIWr, EXE_LOWr}), 32'd4);
    next_cycle();
    @(negedge clk);
    chk({tag, " ctl"}, 32'({EXE_MDUBusy, EXE_HIWr, EXE_LOWr}), 32'd3);
    chk({tag, " hi"}, EXE_HI, p[63:32]);
    chk({tag, " lo"}, EXE_LO, p[31:0]);
    next_cycle();
    chk_idle({tag, " after"});
`else
    chk({tag, " nop_ctl"}, 32'({EXE_MDUBusy, EXE_HIWr, EXE_LOWr}), 32'd0);
    next_cycle();
    chk_idle({tag, " nop_after"});
`endif
  endtask

  initial begin
    bit          any_wr;
    logic [2:0]  op;
    logic [31:0] a, b;

    rst       = 1'b1;
    EXE_MDUOp = MDU_NOP;
    EXE_SrcA  = '0;
    EXE_SrcB  = '0;
    EXE_Flush = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk_idle("reset");

    run_div(MDU_DIVU, 32'd100, 32'd7, "divu_100_7");
    run_div(MDU_DIV, 32'hFFFF_FF9C, 32'd7, "div_m100_7");
    run_div(MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
    run_div(MDU_DIVU, 32'd5, 32'd0, "divu_by0");
    run_div(MDU_DIV, 32'hFFFF_FFF6, 32'd0, "div_neg_by0");
    run_div(MDU_DIV, 32'd100, 32'hFFFF_FFF9, "div_100_m7");
    run_mt(MDU_MTHI, 32'h1234_5678, "mthi");
    run_mt(MDU_MTLO, 32'hCAFE_F00D, "mtlo");
    run_mul(MDU_MULT, 32'hFFFF_FFFF, 32'd2, "mult_m1_2");
    run_mul(MDU_MULTU, 32'hFFFF_FFFF, 32'd2, "multu_max_2");

    // Flush at DIV step 10: nothing may be written, unit must be idle right after.
    EXE_MDUOp = MDU_DIVU;
    EXE_SrcA  = 32'd1000;
    EXE_SrcB  = 32'd3;
    any_wr    = 0;
    for (int c = 0; c <= 10; c++) begin
      if (c == 10) EXE_Flush = 1'b1;
      @(negedge clk);
      if (EXE_HIWr || EXE_LOWr) any_wr = 1;
      if (c == 10) chk("flush_cycle ctl", 32'({EXE_MDUBusy, EXE_HIWr, EXE_LOWr}), 32'd0);
      next_cycle();
    end
    @(negedge clk);
    chk("flush_next busy", 32'(EXE_MDUBusy), 32'd0);
    for (int c = 0; c < 40; c++) begin
      if (EXE_HIWr || EXE_LOWr) any_wr = 1;
      next_cycle();
      @(negedge clk);
    end
    chk("flush_no_wr", 32'(any_wr), 32'd0);
    next_cycle();
    run_div(MDU_DIVU, 32'd9, 32'd3, "divu_9_3");

    // Back-to-back divides in the cycle right after DONE.
    run_div(MDU_DIVU, 32'hFFFF_FFFF, 32'd16, "b2b_1");
    run_div(MDU_DIV, 32'h8000_0001, 32'd2, "b2b_2");

    // Reset mid-DIV discards the operation.
    EXE_MDUOp = MDU_DIVU;
    EXE_SrcA  = 32'd77;
    EXE_SrcB  = 32'd5;
    for (int c = 0; c < 15; c++) next_cycle();
    rst = 1'b1;
    next_cycle();
    rst    = 1'b0;
    any_wr = 0;
    chk_idle("rst_mid");
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (EXE_HIWr || EXE_LOWr || EXE_MDUBusy) any_wr = 1;
      next_cycle();
    end
    chk("rst_mid_no_activity", 32'(any_wr), 32'd0);

    for (int i = 0; i < 16; i++) begin
      op = ($urandom_range(0, 1) == 0) ? MDU_DIV : MDU_DIVU;
      a  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 200)) : $urandom;
      case ($urandom_range(0, 3))
        0:       b = 32'd0;
        1:       b = 32'($urandom_range(1, 15));
        2:       b = -32'($urandom_range(1, 15));
        default: b = $urandom;
      endcase
      run_div(op, a, b, $sformatf("rand%0d", i));
      if ($urandom_range(0, 1) == 0)
        run_mt(($urandom_range(0, 1) == 0) ? MDU_MTHI : MDU_MTLO, $urandom, $sformatf("rmt%0d", i));
      if ($urandom_range(0, 3) == 0)
        run_mul(($urandom_range(0, 1) == 0) ? MDU_MULT : MDU_MULTU, $urandom, $urandom,
                $sformatf("rmul%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
